// File: rtl/ic1337_share_pkg.sv
// Shared types and constants for the ic1337 sharing controller.
package ic1337_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] IDLE_VEC = 3'b000;

  // Bit positions of the device outputs inside {Z,Q1,Q0}
  localparam int RES_Z  = 2;
  localparam int RES_Q1 = 1;
  localparam int RES_Q0 = 0;

endpackage

// File: rtl/ic1337_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; the pointer lives in the parent.
module rr_arb2
  import ic1337_share_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       enable,
  output logic [1:0] win
);

  // NOTE: assign every always_comb output a default first so no latch is inferred.
  always_comb begin
    win = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = last_owner ? 2'b01 : 2'b10;
        default: win = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ic1337_share_ctrl.sv
// Time-shares one ic1337 device between two requesters, holding each vector HOLD_CYCLES edges.
// Optional per-requester completed-operation counters when IC1337_SHARE_STATS_EN is defined.
module ic1337_share_ctrl
  import ic1337_share_pkg::*;
#(
  parameter int         HOLD_CYCLES = 1,
  parameter logic [2:0] IDLE_IN     = IDLE_VEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] in0,
  input  logic       req1,
  input  logic [2:0] in1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [2:0] result,
  output logic       busy,
  output logic [2:0] dev_i,
  input  logic [2:0] dev_q
`ifdef IC1337_SHARE_STATS_EN
  ,
  output logic [7:0] ops0,
  output logic [7:0] ops1
`endif
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner;       // 1 = requester 1 owns the current operation
  logic          last_owner;  // round-robin pointer
  logic [2:0]    dev_vec;     // sole source of dev_i
  logic [1:0]    win;

  rr_arb2 u_arb (
    .req        ({req1, req0}),
    .last_owner (last_owner),
    .enable     (state == IDLE),
    .win        (win)
  );

  assign dev_i = dev_vec;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;  // requester 0 wins the first contention
      dev_vec    <= IDLE_IN;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      result     <= 3'b000;
    end else begin
      unique case (state)
        IDLE: begin
          if (win != 2'b00) begin
            state   <= APPLY;
            cnt     <= '0;
            owner   <= win[1];
            gnt0    <= win[0];
            gnt1    <= win[1];
            busy    <= 1'b1;
            dev_vec <= win[1] ? in1 : in0;
          end
        end
        APPLY: begin
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            result  <= {dev_q[RES_Z], dev_q[RES_Q1], dev_q[RES_Q0]};
            done0   <= ~owner;
            done1   <= owner;
            dev_vec <= IDLE_IN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          last_owner <= owner;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          done0      <= 1'b0;
          done1      <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IC1337_SHARE_STATS_EN
  // Saturating completion counters; an aborted operation never reaches DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops0 <= 8'd0;
      ops1 <= 8'd0;
    end else if (state == DONE) begin
      if (!owner && ops0 != 8'hFF) ops0 <= ops0 + 8'd1;
      if (owner && ops1 != 8'hFF)  ops1 <= ops1 + 8'd1;
    end
  end
`endif

endmodule
